// File: rtl/mdu_ctrl_if.sv
// Bus between the EX stage and the multiply/divide controller.
//   start, op, A, B, cancel : issue side, driven by EX / exception logic
//   HI, LO, busy, done      : MDU state, read by mfhi/mflo and the hazard unit
// master = EX-stage side, slave = mdu_ctrl.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    modport master (
        output start, op, A, B, cancel,
        input  HI, LO, busy, done
    );

    modport slave (
        input  start, op, A, B, cancel,
        output HI, LO, busy, done
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the EX stage. Owns HI/LO, sequences
// multi-cycle mult/multu/div/divu with a busy window and a done pulse,
// and applies single-cycle mthi/mtlo. An op issued together with cancel
// has no effect.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : start/op/A/B/cancel in, HI/LO/busy/done out
//
// state | meaning
// IDLE  | ready to accept an op; mthi/mtlo applied here
// BUSY  | result latched, counting down; HI/LO written when count hits 0
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset_n,
    mdu_ctrl_if.slave bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    hi_r, lo_r;
    logic [31:0]    hi_q, lo_q;
    logic           busy_q, done_q;

    logic           accept, move_to;
    logic [63:0]    res;
    logic signed [31:0] a_s, b_s;

    assign accept  = bus.start & ~bus.cancel & ~bus.op[2];
    assign move_to = bus.start & ~bus.cancel & bus.op[2] & ~bus.op[1];
    assign a_s     = $signed(bus.A);
    assign b_s     = $signed(bus.B);

    // Result computed at issue and held in hi_r/lo_r; the busy window only
    // models the latency the pipeline sees.
    always_comb begin
        res = '0;
        case (bus.op[1:0])
            2'b00: res = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
            2'b01: res = {32'd0, bus.A} * {32'd0, bus.B};
            2'b10: begin
                if (bus.B == 32'd0)
                    res = {bus.A, 32'hFFFF_FFFF};
                else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF)
                    res = {32'd0, 32'h8000_0000};   // quotient overflow wraps
                else
                    res = {32'(a_s % b_s), 32'(a_s / b_s)};
            end
            default: begin
                if (bus.B == 32'd0)
                    res = {bus.A, 32'hFFFF_FFFF};
                else
                    res = {bus.A % bus.B, bus.A / bus.B};
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        hi_r   <= res[63:32];
                        lo_r   <= res[31:0];
                        busy_q <= 1'b1;
                        state  <= BUSY;
                        if (bus.op[1]) begin
                            cnt    <= DIV_LOAD;
                            done_q <= (DIV_LOAD == '0);
                        end else begin
                            cnt    <= MULT_LOAD;
                            done_q <= (MULT_LOAD == '0);
                        end
                    end else if (move_to) begin
                        if (bus.op[0]) lo_q <= bus.A;
                        else           hi_q <= bus.A;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        hi_q   <= hi_r;
                        lo_q   <= lo_r;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt    <= cnt - 1'b1;
                        done_q <= (cnt == CW'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
    logic clk;
    logic reset_n;
    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                           OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts the busy window and, one sample after done, compares
    // HI/LO and the window length with the oldest expectation.
    int          bcount = 0;
    int          seen_len = 0;
    bit          pend = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            bcount = 0;
            pend   = 0;
        end else begin
            if (pend) begin
                exp_t e;
                e = sb.pop_front();
                check("res_hi", bus.HI, e.hi);
                check("res_lo", bus.LO, e.lo);
                check("busy_len", 32'(seen_len), 32'(e.len));
                check("busy_after", {31'd0, bus.busy}, 32'd0);
                pend = 0;
            end
            if (bus.busy) bcount++;
            else          bcount = 0;
            if (bus.done) begin
                check("done_in_busy", {31'd0, bus.busy}, 32'd1);
                if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    seen_len = bcount;
                    pend     = 1;
                end
            end
        end
    end

    // Called at a negedge: drive for one cycle, return at the next negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cncl);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.A      = a;
        bus.B      = b;
        bus.cancel = cncl;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 3'b110;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int len);
        exp_t e;
        e.hi = hi; e.lo = lo; e.len = len;
        sb.push_back(e);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          len;
    } vec_t;

    vec_t vecs[6] = '{
        '{OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 5},
        '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'd1,         32'hFFFF_FFFE, 5},
        '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10},
        '{OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         10},
        '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10},
        '{OP_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, 10}
    };

    initial begin
        logic [31:0] old_hi, old_lo;
        int n;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 3'b110;
        bus.A      = '0;
        bus.B      = '0;
        bus.cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic vectors, issued back-to-back after each completion.
        for (int i = 0; i < 6; i++) begin
            old_hi = bus.HI;
            old_lo = bus.LO;
            push(vecs[i].hi, vecs[i].lo, vecs[i].len);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
            check("busy_c1", {31'd0, bus.busy}, 32'd1);
            check("hold_hi", bus.HI, old_hi);
            check("hold_lo", bus.LO, old_lo);
            wait_idle();
        end

        // mthi then mtlo on consecutive cycles
        bus.start = 1'b1; bus.op = OP_MTHI; bus.A = 32'h1234_5678; bus.cancel = 1'b0;
        @(negedge clk);
        check("mthi_hi", bus.HI, 32'h1234_5678);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);
        bus.op = OP_MTLO; bus.A = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'b110;
        check("mtlo_lo", bus.LO, 32'h9ABC_DEF0);
        check("mtlo_hi", bus.HI, 32'h1234_5678);
        check("mtlo_busy", {31'd0, bus.busy}, 32'd0);

        // Cancelled mthi/mtlo/mult and a no-op leave everything untouched
        issue(OP_MTHI, 32'h1111_1111, 32'd0, 1'b1);
        issue(OP_MTLO, 32'h2222_2222, 32'd0, 1'b1);
        issue(OP_MULT, 32'd3, 32'd3, 1'b1);
        check("cncl_busy", {31'd0, bus.busy}, 32'd0);
        issue(3'b111, 32'h3333_3333, 32'd1, 1'b0);
        check("nop_busy", {31'd0, bus.busy}, 32'd0);
        check("cncl_hi", bus.HI, 32'h1234_5678);
        check("cncl_lo", bus.LO, 32'h9ABC_DEF0);

        // start and cancel during BUSY have no effect on the in-flight mult
        push(32'd0, 32'd42, 5);
        issue(OP_MULT, 32'd6, 32'd7, 1'b0);
        bus.start = 1'b1; bus.op = OP_DIV; bus.A = 32'd100; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0; bus.op = 3'b110;
        wait_idle();
        @(negedge clk);
        check("nostart_busy", {31'd0, bus.busy}, 32'd0);
        check("nostart_lo", bus.LO, 32'd42);

        // Async reset in busy cycle 4 of a div
        issue(OP_DIV, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_done", {31'd0, bus.done}, 32'd0);
        check("arst_hi", bus.HI, 32'd0);
        check("arst_lo", bus.LO, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        push(32'd1, 32'd0, 5);
        issue(OP_MULT, 32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_idle();

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
